// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared MMU types and constants for the CSR read-modify-write master
package mmu_pkg;

  localparam logic [11:0] CSR_SATP_ADDR = 12'h180;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_rmw_state_e;

  // The top two address bits of 2'b11 mark a read-only CSR.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// rtl/csr_rmw_alu.sv - new CSR value and write-needed flag for RW/RS/RC/READ
module csr_rmw_alu
  import mmu_pkg::*;
(
  input  csr_op_e     op,
  input  logic [31:0] old_val,
  input  logic [31:0] wdata,
  output logic [31:0] new_val,
  output logic        need_wr
);

  always_comb begin
    new_val = old_val;
    need_wr = 1'b0;
    case (op)
      CSR_OP_RW: begin
        new_val = wdata;
        need_wr = 1'b1;
      end
      CSR_OP_RS: begin
        new_val = old_val | wdata;
        need_wr = |wdata;
      end
      CSR_OP_RC: begin
        new_val = old_val & ~wdata;
        need_wr = |wdata;
      end
      default: begin
        new_val = old_val;
        need_wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_rmw_master.sv
// rtl/csr_rmw_master.sv - one-at-a-time CSR read/modify/write initiator with response handshake
// Optional satp TLB flush pulse built only when CSR_RMW_SATP_FLUSH_EN is defined.
module csr_rmw_master
  import mmu_pkg::*;
#(
  parameter logic [11:0] SATP_ADDR = CSR_SATP_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        csr_read_en_o,
  output logic [11:0] csr_addr_o,
  input  logic [31:0] csr_rdata_i,
  output logic        csr_write_en_o,
  output logic [11:0] csr_addr_w_o,
  output logic [31:0] csr_wdata_o,
  output logic        tlb_flush_o
);

  csr_rmw_state_e state;
  csr_op_e        op_q;
  logic [11:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    old_q;
  logic           err_q;

  logic [31:0]    alu_new;
  logic           need_wr;
  logic           addr_ro;

  // The ALU sees the read data of the READ cycle, i.e. the value being
  // captured into old_q, so the write data can be registered on that edge.
  csr_rmw_alu u_alu (
    .op      (op_q),
    .old_val (csr_rdata_i),
    .wdata   (wdata_q),
    .new_val (alu_new),
    .need_wr (need_wr)
  );

  assign addr_ro = csr_is_read_only(addr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= CSR_OP_READ;
      addr_q         <= '0;
      wdata_q        <= '0;
      old_q          <= '0;
      err_q          <= 1'b0;
      req_ready_o    <= 1'b1;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      csr_read_en_o  <= 1'b0;
      csr_addr_o     <= '0;
      csr_write_en_o <= 1'b0;
      csr_addr_w_o   <= '0;
      csr_wdata_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q          <= csr_op_e'(req_op_i);
            addr_q        <= req_addr_i;
            wdata_q       <= req_wdata_i;
            err_q         <= 1'b0;
            req_ready_o   <= 1'b0;
            csr_read_en_o <= 1'b1;
            csr_addr_o    <= req_addr_i;
            state         <= ST_READ;
          end
        end
        ST_READ: begin
          csr_read_en_o <= 1'b0;
          csr_addr_o    <= '0;
          old_q         <= csr_rdata_i;
          if (need_wr && addr_ro) begin
            err_q       <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= csr_rdata_i;
            rsp_err_o   <= 1'b1;
            state       <= ST_RESP;
          end else if (need_wr) begin
            csr_write_en_o <= 1'b1;
            csr_addr_w_o   <= addr_q;
            csr_wdata_o    <= alu_new;
            state          <= ST_WRITE;
          end else begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= csr_rdata_i;
            rsp_err_o   <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_WRITE: begin
          csr_write_en_o <= 1'b0;
          csr_addr_w_o   <= '0;
          csr_wdata_o    <= '0;
          rsp_valid_o    <= 1'b1;
          rsp_rdata_o    <= old_q;
          rsp_err_o      <= err_q;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CSR_RMW_SATP_FLUSH_EN
  // Pulse alongside the write strobe; fires even if RS/RC leaves satp unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tlb_flush_o <= 1'b0;
    end else begin
      tlb_flush_o <= (state == ST_READ) && need_wr && !addr_ro && (addr_q == SATP_ADDR);
    end
  end
`else
  logic unused_satp_addr;
  assign unused_satp_addr = ^SATP_ADDR;
  assign tlb_flush_o      = 1'b0;
`endif

endmodule

// File: tb/tb_csr_rmw_master.sv
// tb/tb_csr_rmw_master.sv - randomized scoreboard bench for csr_rmw_master
module tb_csr_rmw_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        csr_read_en_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_rdata_i;
  logic        csr_write_en_o;
  logic [11:0] csr_addr_w_o;
  logic [31:0] csr_wdata_o;
  logic        tlb_flush_o;

  csr_rmw_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .csr_read_en_o  (csr_read_en_o),
    .csr_addr_o     (csr_addr_o),
    .csr_rdata_i    (csr_rdata_i),
    .csr_write_en_o (csr_write_en_o),
    .csr_addr_w_o   (csr_addr_w_o),
    .csr_wdata_o    (csr_wdata_o),
    .tlb_flush_o    (tlb_flush_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file attached to the DUT; preload port used to seed values.
  logic [31:0] csr_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    else if (csr_write_en_o) csr_mem[csr_addr_w_o] <= csr_wdata_o;
  end
  assign csr_rdata_i = csr_mem[csr_addr_o];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    int          acc;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        flush;
    int          acc;
  } wexp_t;

  exp_t        exp_q[$];
  wexp_t       wexp_q[$];
  logic [31:0] ref_mem [logic [11:0]];
  logic [11:0] pool [6];
  logic        hold_ready = 1'b0;
  logic        in_rsp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Response consumer with random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          if (!in_rsp) begin
            in_rsp = 1'b1;
            check("rsp_latency", 32'(cyc - exp_q[0].acc), exp_q[0].wr ? 32'd2 : 32'd1);
          end
          if (rsp_ready_i) begin
            e = exp_q.pop_front();
            in_rsp = 1'b0;
            check("rsp_rdata", rsp_rdata_o, e.rdata);
            check("rsp_err", 32'(rsp_err_o), 32'(e.err));
          end
        end
      end
    end
  end

  // CSR bus monitor: read strobe, write strobe and flush pulse.
  initial begin
    wexp_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (csr_read_en_o) begin
          if (exp_q.size() == 0) begin
            check("read_unexpected", 32'(csr_read_en_o), 32'd0);
          end else begin
            check("read_addr", 32'(csr_addr_o), 32'(exp_q[exp_q.size()-1].addr));
            check("read_cycle", 32'(cyc - exp_q[exp_q.size()-1].acc), 32'd0);
          end
        end
        if (csr_write_en_o) begin
          if (wexp_q.size() == 0) begin
            check("write_unexpected", 32'(csr_write_en_o), 32'd0);
          end else begin
            w = wexp_q.pop_front();
            check("write_addr", 32'(csr_addr_w_o), 32'(w.addr));
            check("write_data", csr_wdata_o, w.data);
            check("write_flush", 32'(tlb_flush_o), 32'(w.flush));
            check("write_cycle", 32'(cyc - w.acc), 32'd1);
          end
        end else if (tlb_flush_o) begin
          check("flush_without_write", 32'(tlb_flush_o), 32'd0);
        end
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    exp_t        e;
    wexp_t       w;
    logic [31:0] old;
    logic [31:0] nv;
    logic        need;
    int          t;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i = op;
    req_addr_i = addr;
    req_wdata_i = wd;
    t = 0;
    while (!req_ready_o && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    old = ref_mem[addr];
    need = (op == 2'd1) || (op != 2'd0 && wd != 32'd0);
    case (op)
      2'd1:    nv = wd;
      2'd2:    nv = old | wd;
      default: nv = old & ~wd;
    endcase
    e.addr = addr;
    e.rdata = old;
    e.err = need && (addr[11:10] == 2'b11);
    e.wr = need && !e.err;
    e.acc = cyc;
    if (e.wr) begin
      ref_mem[addr] = nv;
      w.addr = addr;
      w.data = nv;
`ifdef CSR_RMW_SATP_FLUSH_EN
      w.flush = (addr == 12'h180);
`else
      w.flush = 1'b0;
`endif
      w.acc = cyc;
      wexp_q.push_back(w);
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    check({tag, "_read_en"}, 32'(csr_read_en_o), 32'd0);
    check({tag, "_write_en"}, 32'(csr_write_en_o), 32'd0);
    check({tag, "_wdata"}, csr_wdata_o, 32'd0);
    check({tag, "_flush"}, 32'(tlb_flush_o), 32'd0);
  endtask

  initial begin
    int t;
    pool[0] = 12'h180; pool[1] = 12'h300; pool[2] = 12'h301;
    pool[3] = 12'h340; pool[4] = 12'hC00; pool[5] = 12'hC01;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    for (int i = 0; i < 6; i++) preload(pool[i], $urandom);
    rst_n = 1'b1;

    preload(12'h180, 32'h0);
    issue(2'd1, 12'h180, 32'h8000_1234);
    drain();
    preload(12'h300, 32'h0000_000F);
    issue(2'd2, 12'h300, 32'h0000_00F0);
    drain();
    preload(12'h300, 32'h0000_00FF);
    issue(2'd3, 12'h300, 32'h0000_000F);
    issue(2'd2, 12'h180, 32'h0);
    issue(2'd1, 12'hC00, 32'hDEAD_BEEF);
    issue(2'd0, 12'hC01, 32'h0);
    drain();

    // Backpressure: response must stay stable and no new request accepted.
    hold_ready = 1'b1;
    @(negedge clk);
    issue(2'd1, 12'h301, $urandom);
    t = 0;
    while (!rsp_valid_o && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() == 0) begin
        check("stall_no_expect", 32'd0, 32'd1);
      end else begin
        check("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("stall_rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
        check("stall_rsp_err", 32'(rsp_err_o), 32'(exp_q[0].err));
        check("stall_req_ready", 32'(req_ready_o), 32'd0);
      end
      @(negedge clk);
    end
    hold_ready = 1'b0;
    drain();

    for (int n = 0; n < 150; n++) begin
      issue(2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)],
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    end
    drain();

    // Reset during WRITE aborts the operation.
    issue(2'd1, 12'h301, $urandom);
    t = 0;
    while (!csr_write_en_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("abort_write_seen", 32'(csr_write_en_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    wexp_q.delete();
    in_rsp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
      check("abort_no_write", 32'(csr_write_en_o), 32'd0);
    end

    for (int n = 0; n < 20; n++) begin
      issue(2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)], $urandom);
    end
    drain();
    check("final_rsp_queue", 32'(exp_q.size()), 32'd0);
    check("final_write_queue", 32'(wexp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_rmw_master.md
# csr_rmw_master

Initiator side of the MMU CSR access port: accepts one CSR instruction at a time from the execute stage and performs CSRRW/CSRRS/CSRRC/read-only semantics on the CSR bus. Each instruction is a read cycle followed by an optional write cycle, with the old value returned on a response handshake. Sits between the execute stage and the CSR file that holds `satp`. Optionally raises a TLB flush pulse whenever `satp` is written.

## Interface
Parameters:
- `SATP_ADDR`, 12'h180: CSR address treated as `satp` for the flush feature.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid_i` in 1: a request is present.
- `req_ready_o` out 1: the block accepts a request.
- `req_op_i` in 2: operation; 00 READ, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- `req_addr_i` in 12: CSR address.
- `req_wdata_i` in 32: write value for RW; bit mask for RS/RC.
- `rsp_valid_o` out 1: response is valid.
- `rsp_ready_i` in 1: the consumer takes the response.
- `rsp_rdata_o` out 32: old CSR value.
- `rsp_err_o` out 1: a write was attempted to a read-only CSR (`addr[11:10]==2'b11`).
- `csr_read_en_o` out 1, `csr_addr_o` out 12: CSR read strobe and address.
- `csr_rdata_i` in 32: read data; combinational, valid in the same cycle as `csr_read_en_o`.
- `csr_write_en_o` out 1, `csr_addr_w_o` out 12, `csr_wdata_o` out 32: CSR write port.
- `tlb_flush_o` out 1: one-cycle flush pulse (see Configuration).

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready_o`=1; all other outputs are 0.
  - On `req_valid_i`, latch op, addr and wdata, then go to READ.
- READ:
  - Assert `csr_read_en_o` with `csr_addr_o`=latched addr.
  - Capture `csr_rdata_i` into `old_q`.
  - Compute `need_wr`: op==RW, or op RS/RC with mask!=0.
  - If `need_wr` and the CSR is read-only: set `err_q`, suppress the write, go to RESP.
  - Else if `need_wr`: go to WRITE.
  - Else: go to RESP.
- WRITE:
  - Assert `csr_write_en_o` for exactly one cycle, with `csr_addr_w_o`=addr.
  - `csr_wdata_o` is computed from `old_q`:
    - RW: wdata.
    - RS: `old_q | wdata`.
    - RC: `old_q & ~wdata`.
  - Go to RESP.
- RESP:
  - `rsp_valid_o`=1, `rsp_rdata_o`=`old_q`, `rsp_err_o`=`err_q`.
  - Hold all three stable until `rsp_ready_i`, then go to IDLE.
- READ with mask 0 (op READ, or RS/RC with zero mask) never writes and never errors, even to a read-only CSR.
- `req_ready_o` is 0 outside IDLE. Requests there are not accepted and must be held by the requester.

## Timing
- Reset (`rst_n` low at a `clk` edge): state returns to IDLE. All outputs are 0 except `req_ready_o`=1. `old_q` and `err_q` are cleared.
- Reset mid-operation aborts the operation: no write strobe and no response is issued afterwards.
- Latency, with the accept edge at cycle 0:
  - READ strobe in cycle 1.
  - WRITE strobe in cycle 2, `rsp_valid_o` from cycle 3.
  - Without a write, `rsp_valid_o` from cycle 2.
- Back-to-back throughput: the response handshake cycle returns to IDLE, so the next accept happens one cycle later. Minimum spacing is 4 cycles with a write, 3 without.
- Read-after-write across requests is coherent: the write commits at the end of the WRITE cycle, before any later READ.

## Configuration
- `CSR_RMW_SATP_FLUSH_EN` defined:
  - `tlb_flush_o`=1 in the same cycle as `csr_write_en_o` when addr==`SATP_ADDR`.
  - Also asserted for an RS/RC write that leaves the value unchanged.
- Not defined: `tlb_flush_o` is tied to 0 and no comparator logic is built.

## Structure
- `mmu_pkg` gains:
  - a `csr_op_e` enum (READ/RW/RS/RC, 2 bits);
  - a `csr_rmw_state_e` enum;
  - the `CSR_SATP_ADDR` constant (12'h180), which is the default of `SATP_ADDR`.
- One natural combinational sub-module, `csr_rmw_alu`, computes `csr_wdata_o` and `need_wr` from op, `old_q` and wdata. The FSM stays in the top.

## Test plan
- RW to 0x180, wdata 0x8000_1234, CSR holds 0:
  - READ in cycle 1, WRITE with 0x8000_1234 in cycle 2.
  - `rsp_rdata_o`=0 in cycle 3.
  - `tlb_flush_o` pulses in cycle 2 when the macro is defined, otherwise stays 0.
- RS mask 0x0000_00F0 on a CSR holding 0x0000_000F: writes 0x0000_00FF and returns 0x0000_000F.
- RC mask 0x0000_000F on a CSR holding 0x0000_00FF: writes 0x0000_00F0.
- RS mask 0 on 0x180: no write strobe, `rsp_valid_o` in cycle 2, `tlb_flush_o` stays 0.
- RW to 0xC00 (read-only): no write strobe, `rsp_err_o`=1 with the old value returned.
- Hold `rsp_ready_i`=0 for 5 cycles:
  - The response stays stable and `req_ready_o` stays 0.
  - Assert `rst_n`=0 during WRITE: the next cycle is IDLE with all outputs at reset values and no response.
